// File: rtl/seg7_pkg.sv
// Segment patterns and idle levels for the seven-segment scan driver.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [3:0] GND_OFF = 4'b1111;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bus: value/load in from the core side, digit commons and
// segment lines out to the panel.
interface seg7_scan_driver_if;

  logic [15:0] value;
  logic        load;
  logic [3:0]  grounds;
  logic [6:0]  display;

  modport master (
    output value,
    output load,
    input  grounds,
    input  display
  );

  modport slave (
    input  value,
    input  load,
    output grounds,
    output display
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment pattern decoder.
// Covers all sixteen codes, so no default pattern is ever emitted.
module hex_to_seg7 (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  import seg7_pkg::*;

  always_comb begin
    seg = SEG_OFF;
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed hex display with snapshot shadow and anti-ghost blanking.
// Define LEADING_ZERO_BLANK_EN to suppress leading zero digits 3..1.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  import seg7_pkg::*;

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYCLES);

  logic [15:0]   shadow;
  logic [PW-1:0] presc;
  logic [1:0]    digit;
  logic [3:0]    nib;
  logic [3:0]    grounds;
  logic [6:0]    display;

  logic          slot_start;
  logic [3:0]    nib_cur;
  logic [6:0]    seg;
  logic          show;

  assign slot_start = (presc == '0);

  // At slot start the latch is being loaded; use the incoming nibble.
  assign nib_cur = slot_start ? shadow[{digit, 2'b00} +: 4] : nib;

  hex_to_seg7 u_dec (
    .nib (nib_cur),
    .seg (seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic lz;
  logic lz_now;
  logic lz_cur;

  always_comb begin
    lz_now = 1'b0;
    unique case (digit)
      2'd3: lz_now = (shadow[15:12] == 4'h0);
      2'd2: lz_now = (shadow[15:8] == 8'h00);
      2'd1: lz_now = (shadow[15:4] == 12'h000);
      2'd0: lz_now = 1'b0;
    endcase
  end

  assign lz_cur = slot_start ? lz_now : lz;
  assign show   = (presc >= BLANK) && !lz_cur;

  always_ff @(posedge clk) begin
    if (!rst_n)
      lz <= 1'b0;
    else if (slot_start)
      lz <= lz_now;
  end
`else
  assign show = (presc >= BLANK);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow  <= '0;
      presc   <= '0;
      digit   <= '0;
      nib     <= '0;
      grounds <= GND_OFF;
      display <= SEG_OFF;
    end else begin
      if (bus.load)
        shadow <= bus.value;
      if (presc == LAST) begin
        presc <= '0;
        digit <= digit + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (slot_start)
        nib <= nib_cur;
      grounds <= show ? ~(4'b0001 << digit) : GND_OFF;
      display <= show ? seg : SEG_OFF;
    end
  end

  assign bus.grounds = grounds;
  assign bus.display = display;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised and directed bench for seg7_scan_driver against a slot-level model.
// Build with +define+LEADING_ZERO_BLANK_EN to check the zero-suppressing variant.
module tb_seg7_scan_driver;

  localparam int DIV = 8;
  localparam int BLK = 2;

  logic clk;
  logic rst_n;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_ref [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int checks = 0;
  int errors = 0;

  int          t;
  logic [15:0] m_shadow;
  logic [15:0] snap;
  int          cnt_d0;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Called at a negedge: drive, advance one clock, compare, return at negedge.
  task automatic step(input logic r, input logic l, input logic [15:0] v);
    int   pos;
    int   dig;
    bit   blank;
    logic [3:0] eg;
    logic [6:0] ed;
    rst_n     = r;
    bus.load  = l;
    bus.value = v;
    @(posedge clk);
    if (!r) begin
      eg       = 4'b1111;
      ed       = 7'b0;
      m_shadow = 16'h0;
      t        = 0;
    end else begin
      pos = t % DIV;
      dig = (t / DIV) % 4;
      if (pos == 0)
        snap = m_shadow;
      blank = (pos < BLK);
`ifdef LEADING_ZERO_BLANK_EN
      if (dig > 0 && (snap >> (4 * dig)) == 16'h0)
        blank = 1'b1;
`endif
      eg = blank ? 4'b1111 : ~(4'b0001 << dig);
      ed = blank ? 7'b0 : seg_ref[(snap >> (4 * dig)) & 16'hF];
      if (l)
        m_shadow = v;
      t++;
    end
    #1;
    check("grounds", {12'h0, bus.grounds}, {12'h0, eg});
    check("display", {9'h0, bus.display}, {9'h0, ed});
    if (bus.grounds == 4'b1110)
      cnt_d0++;
    @(negedge clk);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 16'($urandom));
  endtask

  // Advance until the next cycle is digit d at prescaler p.
  task automatic seek(input int d, input int p);
    for (int i = 0; i < 4 * DIV + 1; i++) begin
      if (((t / DIV) % 4) == d && (t % DIV) == p)
        return;
      step(1'b1, 1'b0, 16'($urandom));
    end
    check("seek_timeout", 16'd1, 16'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.load  = 1'b0;
    bus.value = 16'h0;
    t         = 0;
    m_shadow  = 16'h0;
    snap      = 16'h0;
    cnt_d0    = 0;
    @(negedge clk);

    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 16'hFFFF);
    run_idle(2);

    cnt_d0 = 0;
    step(1'b1, 1'b1, 16'h1234);
    run_idle(39);
    check("d0_show_cycles", 16'(cnt_d0), 16'd12);

    seek(1, 4);
    step(1'b1, 1'b1, 16'h00F0);
    run_idle(40);

    step(1'b1, 1'b1, 16'h0005);
    run_idle(40);
    step(1'b1, 1'b1, 16'h0000);
    run_idle(40);

    step(1'b1, 1'b1, 16'hBEEF);
    run_idle(10);
    seek(2, 5);
    step(1'b0, 1'b0, 16'h0);
    run_idle(12);

    for (int i = 0; i < 300; i++)
      step(1'b1, 1'($urandom), 16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
